// File: rtl/prog_mem_loader.sv
// Program memory for the 4-bit CPU: combinational instruction fetch plus a
// valid/ready byte loader that holds the CPU in reset until a full image is written.
module prog_mem_loader #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] instr,
    output logic              cpu_n_reset,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              ld_done,
    output logic [ADDR_W:0]   ld_count
);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRelease,
        StRun
    } state_e;

    localparam logic [ADDR_W:0] LastCount = (ADDR_W + 1)'(DEPTH - 1);

    state_e            state_q;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wptr_q;
    logic [ADDR_W:0]   count_q;
    logic              cpu_n_reset_q;
    logic              ld_done_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            wptr_q        <= '0;
            count_q       <= '0;
            cpu_n_reset_q <= 1'b0;
            ld_done_q     <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            ld_done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (ld_start) begin
                        state_q       <= StLoad;
                        wptr_q        <= '0;
                        count_q       <= '0;
                        cpu_n_reset_q <= 1'b0;
                    end
                end
                StLoad: begin
                    // A restart wins over a byte presented on the same edge.
                    if (ld_start) begin
                        wptr_q  <= '0;
                        count_q <= '0;
                    end else if (ld_valid) begin
                        mem_q[wptr_q] <= ld_data;
                        wptr_q        <= wptr_q + 1'b1;
                        count_q       <= count_q + 1'b1;
                        if (count_q == LastCount) begin
                            state_q   <= StRelease;
                            ld_done_q <= 1'b1;
                        end
                    end
                end
                StRelease: begin
                    // One full cycle in reset after the last write before the CPU runs.
                    state_q       <= StRun;
                    cpu_n_reset_q <= 1'b1;
                end
                StRun: begin
                    if (ld_start) begin
                        state_q       <= StLoad;
                        wptr_q        <= '0;
                        count_q       <= '0;
                        cpu_n_reset_q <= 1'b0;
                    end
                end
                default: begin
                    state_q       <= StIdle;
                    cpu_n_reset_q <= 1'b0;
                end
            endcase
        end
    end

    assign ld_ready    = (state_q == StLoad);
    assign ld_done     = ld_done_q;
    assign ld_count    = count_q;
    assign cpu_n_reset = cpu_n_reset_q;
    assign instr       = cpu_n_reset_q ? mem_q[address] : '0;

endmodule
